// File: rtl/sap_mem_pkg.sv
// rtl/sap_mem_pkg.sv - shared constants and loader state encoding for the SAP RAM interface
// Contents:
//   SAP_ADDR_W / SAP_DATA_W : default RAM geometry (16 x 8)
//   SAP_RAM_DEPTH           : number of RAM words
//   loader_state_t          : ram_loader FSM states, fixed encodings
package sap_mem_pkg;

    localparam int SAP_ADDR_W    = 4;
    localparam int SAP_DATA_W    = 8;
    localparam int SAP_RAM_DEPTH = 1 << SAP_ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_BYTE = 3'd1,
        ST_SETUP     = 3'd2,
        ST_STROBE    = 3'd3,
        ST_HOLD      = 3'd4,
        ST_RD_SETUP  = 3'd5,
        ST_RD_WAIT   = 3'd6,
        ST_DONE      = 3'd7
    } loader_state_t;

endpackage

// File: rtl/ram_loader_strobe_timer.sv
// rtl/ram_loader_strobe_timer.sv - loadable down-counter timing the write strobe and read wait
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   load        : start an interval of (load_value + 1) cycles
//   load_value  : interval length minus one
//   expire      : high during the final cycle of the interval
module strobe_timer #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             expire
);

    logic [CNT_W-1:0] count;
    logic             active;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            active <= 1'b0;
        end else if (load) begin
            count  <= load_value;
            active <= 1'b1;
        end else if (active) begin
            if (count == '0) begin
                active <= 1'b0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    assign expire = active && (count == '0);

endmodule

// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - streams bytes into consecutive SAP RAM addresses with setup/strobe/hold timing
// Optional read-back verify: define RAM_LOADER_VERIFY_EN.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   start, length         : begin a load of min(length, depth) words
//   in_data/in_valid/in_ready : byte stream handshake
//   mem_address, mem_data : RAM address and write data
//   mem_write_enable_n    : RAM write strobe, active low
//   mem_enable_n          : RAM output enable, active low (verify only)
//   mem_bus_in            : RAM read bus, carries the inverted stored word
//   busy, done            : load in progress, one-cycle completion pulse
//   checksum              : modular sum of bytes written by the last load
//   verify_error          : read-back sum differed from checksum
module ram_loader
    import sap_mem_pkg::*;
#(
    parameter int ADDR_W    = SAP_ADDR_W,
    parameter int DATA_W    = SAP_DATA_W,
    parameter int WE_PULSE  = 1,
    parameter int READ_WAIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_write_enable_n,
    output logic              mem_enable_n,
    input  logic [DATA_W-1:0] mem_bus_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    output logic              verify_error
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam int TMR_MAX = (WE_PULSE > READ_WAIT) ? WE_PULSE : READ_WAIT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    loader_state_t     state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] sum_q;
    logic [ADDR_W:0]   n_q;
    logic [ADDR_W:0]   widx;
    logic [ADDR_W:0]   widx_next;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_value;
    logic              tmr_expire;

    assign widx_next = widx + 1'b1;

    // One timer serves both the write strobe and the read wait; the two
    // intervals never overlap, so the load value is chosen by state.
    assign tmr_load  = (state == ST_SETUP) || (state == ST_RD_SETUP);
    assign tmr_value = (state == ST_SETUP) ? TMR_W'(WE_PULSE - 1) : TMR_W'(READ_WAIT - 1);

    strobe_timer #(
        .CNT_W(TMR_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (tmr_load),
        .load_value(tmr_value),
        .expire    (tmr_expire)
    );

`ifdef RAM_LOADER_VERIFY_EN
    logic [DATA_W-1:0] rsum_q;
    logic [DATA_W-1:0] rsum_next;
    logic              verr_q;

    // The RAM returns the complement of the stored word.
    assign rsum_next = rsum_q + ~mem_bus_in;
`else
    logic unused_bus;
    assign unused_bus = ^mem_bus_in;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            addr_q <= '0;
            data_q <= '0;
            sum_q  <= '0;
            n_q    <= '0;
            widx   <= '0;
`ifdef RAM_LOADER_VERIFY_EN
            rsum_q <= '0;
            verr_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        n_q    <= (length > DEPTH) ? DEPTH : length;
                        addr_q <= '0;
                        widx   <= '0;
                        sum_q  <= '0;
`ifdef RAM_LOADER_VERIFY_EN
                        rsum_q <= '0;
                        verr_q <= 1'b0;
`endif
                        state  <= (length == '0) ? ST_DONE : ST_WAIT_BYTE;
                    end
                end
                ST_WAIT_BYTE: begin
                    if (in_valid) begin
                        data_q <= in_data;
                        sum_q  <= sum_q + in_data;
                        state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    state <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (tmr_expire) begin
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Counting words rather than comparing addresses lets a
                    // full-depth load finish without wrapping back to 0.
                    if (widx_next == n_q) begin
`ifdef RAM_LOADER_VERIFY_EN
                        widx   <= '0;
                        addr_q <= '0;
                        state  <= ST_RD_SETUP;
`else
                        state  <= ST_DONE;
`endif
                    end else begin
                        widx   <= widx_next;
                        addr_q <= addr_q + 1'b1;
                        state  <= ST_WAIT_BYTE;
                    end
                end
`ifdef RAM_LOADER_VERIFY_EN
                ST_RD_SETUP: begin
                    state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (tmr_expire) begin
                        rsum_q <= rsum_next;
                        addr_q <= addr_q + 1'b1;
                        widx   <= widx_next;
                        if (widx_next == n_q) begin
                            verr_q <= (rsum_next != sum_q);
                            state  <= ST_DONE;
                        end else begin
                            state  <= ST_RD_SETUP;
                        end
                    end
                end
`endif
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from state so reset releases them at once.
    assign in_ready           = (state == ST_WAIT_BYTE);
    assign mem_address        = addr_q;
    assign mem_data           = data_q;
    assign mem_write_enable_n = (state != ST_STROBE);
    assign busy               = (state != ST_IDLE) && (state != ST_DONE);
    assign done               = (state == ST_DONE);
    assign checksum           = sum_q;

`ifdef RAM_LOADER_VERIFY_EN
    assign mem_enable_n = !((state == ST_RD_SETUP) || (state == ST_RD_WAIT));
    assign verify_error = verr_q;
`else
    assign mem_enable_n = 1'b1;
    assign verify_error = 1'b0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// tb/tb_ram_loader.sv - randomized self-checking bench for ram_loader against a queue-based write model
module tb_ram_loader;

    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;
    localparam int WE_PULSE  = 1;
    localparam int READ_WAIT = 1;
    localparam int DEPTH     = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   length;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_write_enable_n;
    logic              mem_enable_n;
    logic [DATA_W-1:0] mem_bus_in;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;
    logic              verify_error;

    ram_loader #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .WE_PULSE (WE_PULSE),
        .READ_WAIT(READ_WAIT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .length            (length),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .mem_address       (mem_address),
        .mem_data          (mem_data),
        .mem_write_enable_n(mem_write_enable_n),
        .mem_enable_n      (mem_enable_n),
        .mem_bus_in        (mem_bus_in),
        .busy              (busy),
        .done              (done),
        .checksum          (checksum),
        .verify_error      (verify_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t         exp_writes[$];
    logic [7:0]  exp_sum  = 8'h00;
    logic        exp_verr = 1'b0;
    logic [7:0]  ram [DEPTH];
    logic [7:0]  stuck_mask = 8'h00;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    int          cyc      = 0;

    // RAM model: complemented read, with optional bits stuck at 0 on the bus.
    assign mem_bus_in = mem_enable_n ? 8'h00 : (~ram[mem_address] & ~stuck_mask);

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the expected write list and done values.
    logic       prev_we = 1'b1;
    int         low_len = 0;
    logic [3:0] prev_addr, strobe_addr;
    logic [7:0] prev_data, strobe_data;

    always @(negedge clk) begin
        if (reset) begin
            prev_we = 1'b1;
            low_len = 0;
        end else begin
            chk("strobe_overlap", 32'(mem_write_enable_n | mem_enable_n), 1);
`ifndef RAM_LOADER_VERIFY_EN
            chk("enable_n_const", 32'(mem_enable_n), 1);
`endif
            if (!mem_write_enable_n) begin
                if (prev_we) begin
                    chk("setup_addr_stable", 32'(mem_address), 32'(prev_addr));
                    chk("setup_data_stable", 32'(mem_data), 32'(prev_data));
                    chk("write_expected", 32'(exp_writes.size() != 0), 1);
                    if (exp_writes.size() != 0) begin
                        wr_t w;
                        w = exp_writes.pop_front();
                        chk("write_addr", 32'(mem_address), 32'(w.addr));
                        chk("write_data", 32'(mem_data), 32'(w.data));
                    end
                    strobe_addr = mem_address;
                    strobe_data = mem_data;
                    ram[mem_address] = mem_data;
                    low_len = 0;
                end
                low_len++;
            end else if (!prev_we) begin
                chk("we_pulse_len", 32'(low_len), WE_PULSE);
                chk("hold_addr_stable", 32'(mem_address), 32'(strobe_addr));
                chk("hold_data_stable", 32'(mem_data), 32'(strobe_data));
            end
            if (done) begin
                chk("done_busy", 32'(busy), 0);
                chk("done_checksum", 32'(checksum), 32'(exp_sum));
                chk("done_verify_error", 32'(verify_error), 32'(exp_verr));
                chk("done_writes_left", 32'(exp_writes.size()), 0);
                done_cnt++;
            end
            prev_we   = mem_write_enable_n;
            prev_addr = mem_address;
            prev_data = mem_data;
        end
    end

    task automatic run_load(input int len, input logic [7:0] bytes[$], input int max_gap,
                            input bit bp, input bit poke_start);
        int         n;
        int         t;
        int         gap;
        int         last_gap;
        int         prev_t;
        int         done0;
        logic [7:0] s;
        logic [7:0] rs;
        n  = (len > DEPTH) ? DEPTH : len;
        s  = 8'h00;
        rs = 8'h00;
        exp_writes.delete();
        for (int i = 0; i < n; i++) begin
            exp_writes.push_back('{addr: i[3:0], data: bytes[i]});
            s  = s + bytes[i];
            rs = rs + (bytes[i] | stuck_mask);
        end
        exp_sum = s;
`ifdef RAM_LOADER_VERIFY_EN
        exp_verr = (rs != s);
`else
        exp_verr = 1'b0;
`endif
        done0  = done_cnt;
        start  = 1'b1;
        length = len[4:0];
        @(negedge clk);
        start = 1'b0;
        if (n == 0) chk("len0_done_next_cycle", 32'(done), 1);
        last_gap = 1;
        prev_t   = 0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = bytes[i];
            t = 0;
            while (!in_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            chk("in_ready_timeout", 32'(in_ready), 1);
            if (i > 0 && last_gap == 0) chk("byte_to_byte_latency", 32'(cyc - prev_t), WE_PULSE + 3);
            prev_t = cyc;
            if (poke_start && i == 0) begin
                start  = 1'b1;
                length = 5'd1;
            end
            @(negedge clk);
            start    = 1'b0;
            in_valid = 1'b0;
            if (bp && i + 1 < n) begin
                t = 0;
                while (!in_ready && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                for (int k = 0; k < 5; k++) begin
                    chk("bp_in_ready_held", 32'(in_ready), 1);
                    chk("bp_no_strobe", 32'(mem_write_enable_n), 1);
                    @(negedge clk);
                end
                last_gap = 1;
            end else begin
                gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
                repeat (gap) @(negedge clk);
                last_gap = gap;
            end
        end
        t = 0;
        while (done_cnt == done0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("done_pulse_count", 32'(done_cnt - done0), 1);
    endtask

    initial begin
        logic [7:0] q[$];
        int         t;
        for (int i = 0; i < DEPTH; i++) ram[i] = 8'h00;
        reset    = 1'b1;
        start    = 1'b0;
        length   = '0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        #12;
        chk("rst_we_n", 32'(mem_write_enable_n), 1);
        chk("rst_en_n", 32'(mem_enable_n), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_checksum", 32'(checksum), 0);
        @(negedge clk);
        reset = 1'b0;

        // Stream data offered with no load active must not be taken.
        in_valid = 1'b1;
        in_data  = 8'h3C;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("idle_in_ready", 32'(in_ready), 0);
        end
        in_valid = 1'b0;

        q = '{8'hAA, 8'hCC};
        run_load(2, q, 0, 1'b1, 1'b0);
        chk("load2_checksum", 32'(checksum), 32'h76);

        q.delete();
        for (int i = 0; i < 16; i++) q.push_back(i[7:0]);
        run_load(16, q, 0, 1'b0, 1'b0);
        chk("full16_checksum", 32'(checksum), 32'h78);
        run_load(31, q, 0, 1'b0, 1'b0);
        chk("len31_checksum", 32'(checksum), 32'h78);

        q.delete();
        run_load(0, q, 0, 1'b0, 1'b0);
        chk("len0_checksum", 32'(checksum), 0);

        for (int r = 0; r < 10; r++) begin
            int len;
            len = $urandom_range(31, 0);
            q.delete();
            for (int i = 0; i < 32; i++) q.push_back(8'($urandom));
            run_load(len, q, 3, 1'b0, (r % 3) == 1);
        end

`ifdef RAM_LOADER_VERIFY_EN
        q = '{8'h5A, 8'hA5};
        stuck_mask = 8'h00;
        run_load(2, q, 0, 1'b0, 1'b0);
        chk("verify_clean", 32'(verify_error), 0);
        stuck_mask = 8'h01;
        run_load(2, q, 0, 1'b0, 1'b0);
        chk("verify_stuck_bit", 32'(verify_error), 1);
        stuck_mask = 8'h00;
`endif

        // Reset in the middle of a write strobe.
        q = '{8'h11, 8'h22, 8'h33};
        exp_writes.delete();
        exp_writes.push_back('{addr: 4'd0, data: 8'h11});
        start  = 1'b1;
        length = 5'd3;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h11;
        t = 0;
        while (mem_write_enable_n && t < 50) begin
            @(negedge clk);
            in_valid = in_ready ? in_valid : 1'b0;
            t++;
        end
        in_valid = 1'b0;
        chk("mid_strobe_reached", 32'(mem_write_enable_n), 0);
        #2 reset = 1'b1;
        #1;
        chk("midrst_we_n", 32'(mem_write_enable_n), 1);
        chk("midrst_en_n", 32'(mem_enable_n), 1);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_in_ready", 32'(in_ready), 0);
        chk("midrst_address", 32'(mem_address), 0);
        chk("midrst_data", 32'(mem_data), 0);
        chk("midrst_checksum", 32'(checksum), 0);
        chk("midrst_verify_error", 32'(verify_error), 0);
        exp_writes.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
Initiator for the 16x8 SAP RAM interface. It accepts a byte stream over a valid/ready handshake and writes the bytes to consecutive RAM addresses. It drives the RAM's active-low write and output-enable strobes with a setup/strobe/hold sequence. It sits between the host byte source and the RAM, replacing the DIP-switch programming path used at boot.

Parameters:
ADDR_W, 4, RAM address width; depth = 2**ADDR_W
DATA_W, 8, RAM word width
WE_PULSE, 1, cycles write_enable_n is held low per word (>=1)
READ_WAIT, 1, cycles from enable_n low to sampling bus_in (verify only, >=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a load; ignored while busy
length  in  ADDR_W+1  words to load; sampled on accepted start
in_data  in  DATA_W  stream byte
in_valid  in  1  stream byte valid
in_ready  out  1  loader can accept a byte
mem_address  out  ADDR_W  RAM address
mem_data  out  DATA_W  RAM write data
mem_write_enable_n  out  1  RAM write strobe, active low
mem_enable_n  out  1  RAM output enable, active low
mem_bus_in  in  DATA_W  RAM bus_out; RAM returns the inverted stored word
busy  out  1  load or verify in progress
done  out  1  one-cycle pulse at completion
checksum  out  DATA_W  mod-2**DATA_W sum of all bytes written in the last load
verify_error  out  1  read-back sum mismatched checksum; held until next start

Behaviour:
- Reset (async, any state): all outputs 0 except mem_write_enable_n=1 and mem_enable_n=1. FSM goes to IDLE. A write in flight is aborted with the strobe deasserted immediately.
- States: IDLE, WAIT_BYTE, SETUP, STROBE, HOLD, RD_SETUP, RD_WAIT, DONE.
- IDLE: on start=1, latch n=min(length, 2**ADDR_W), clear address/checksum/verify_error, set busy=1.
  - If n=0, go to DONE.
  - Otherwise go to WAIT_BYTE.
- WAIT_BYTE: in_ready=1. A transfer is in_valid&in_ready. On transfer, capture in_data into mem_data, add it to checksum, and go to SETUP. in_ready is 0 in every other state.
- SETUP (1 cycle): address and data stable, write_enable_n=1, then go to STROBE.
- STROBE: write_enable_n=0 for exactly WE_PULSE cycles, then go to HOLD.
- HOLD (1 cycle): write_enable_n=1, address and data unchanged.
  - If this was the last word, go to RD_SETUP with address=0 (verify built) or DONE (otherwise).
  - Else address+1, go to WAIT_BYTE.
- Latency: byte accepted at edge N; write_enable_n low from N+1 through N+WE_PULSE; in_ready high again at N+WE_PULSE+2.
- Address wraps within ADDR_W bits. n=2**ADDR_W writes 0..15 and never wraps onto address 0.
- mem_enable_n stays 1 throughout all write states. write_enable_n and enable_n are never low in the same cycle.
- DONE (1 cycle): done=1, busy=0, then IDLE. checksum and verify_error hold until the next accepted start.
- start during busy is ignored. in_valid with no load active is not consumed.

Optional Feature:
RAM_LOADER_VERIFY_EN
- Defined: after the last HOLD, read back each loaded address.
  - RD_SETUP: drive address, enable_n=0.
  - RD_WAIT: wait READ_WAIT cycles, then add ~mem_bus_in to a read sum.
  - Increment address; after n words go to DONE. verify_error = (read sum != checksum), valid in the done cycle.
  - enable_n returns to 1 in DONE.
- Undefined: RD_* states are absent, mem_enable_n is constant 1, verify_error is constant 0.

Decomposition:
- Package sap_mem_pkg: ADDR_W/DATA_W defaults, RAM depth constant, loader state enum.
- One sub-module, strobe_timer: loadable down-counter producing the WE_PULSE/READ_WAIT interval and an expire pulse. It is shared by STROBE and RD_WAIT.

Test Plan:
- Reset: reset=1 mid-STROBE -> write_enable_n=1 the same cycle, all outputs at reset values, busy=0.
- Load 2: start, length=2, stream 8'hAA, 8'hCC.
  - Response: writes to addr 0 and 1, each write_enable_n low exactly 1 cycle (WE_PULSE=1) with address/data stable one cycle either side.
  - checksum=8'h76, done pulses once.
- Backpressure: in_valid low for 5 cycles between bytes -> FSM stays in WAIT_BYTE, no strobe, in_ready held 1.
- Full depth, no wrap: length=16 then length=31, stream 0..15 -> 16 writes to addresses 0..15, no 17th write, checksum=8'h78 in both cases.
- length=0 -> no strobes, done one cycle after start, checksum=0.
- VERIFY_EN on a RAM model that inverts on read:
  - Load 8'h5A, 8'hA5 -> verify_error=0.
  - Force a stuck bit on read-back -> verify_error=1 in the done cycle.
  - enable_n is never low while write_enable_n is low.
